// File: rtl/decode_pipe.sv
// RV32I ID-stage decoder with a 2-entry skid buffer.
// Decoded fields are captured on accept; in_ready is registered.
module decode_pipe #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] instr,
  input  logic [XLEN-1:0] pc_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_out,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      fn3,
  output logic            fn7_5,
  output logic            fn7_1,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  if (ILEN != 32) begin : g_ilen
    $error("decode_pipe: only ILEN=32 is supported");
  end
  if (XLEN < 32) begin : g_xlen
    $error("decode_pipe: XLEN must be >= 32");
  end

  localparam logic [2:0] F_R    = 3'd0;
  localparam logic [2:0] F_I    = 3'd1;
  localparam logic [2:0] F_S    = 3'd2;
  localparam logic [2:0] F_B    = 3'd3;
  localparam logic [2:0] F_U    = 3'd4;
  localparam logic [2:0] F_J    = 3'd5;
  localparam logic [2:0] F_NONE = 3'd7;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      fn3;
    logic            fn7_5;
    logic            fn7_1;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  function automatic logic [XLEN-1:0] sext(
    input logic [31:0] v
  );
    return XLEN'($signed(v));
  endfunction

  state_t state_q, state_d;
  entry_t head, tail, dec;
  logic   push, pop;
  logic   is_r, is_i, is_s, is_b, is_u, is_j;
  logic [6:0] op;

  assign op   = instr[6:0];
  assign is_r = (op == 7'b0110011);
  assign is_i = (op == 7'b0010011)
             || (op == 7'b0000011)
             || (op == 7'b1100111);
  assign is_s = (op == 7'b0100011);
  assign is_b = (op == 7'b1100011);
  assign is_u = (op == 7'b0110111)
             || (op == 7'b0010111);
  assign is_j = (op == 7'b1101111);

  always_comb begin
    dec        = '0;
    dec.pc     = pc_in;
    dec.opcode = op;
    dec.fmt    = F_NONE;
    unique case (1'b1)
      is_r: begin
        dec.fmt   = F_R;
        dec.rd    = instr[11:7];
        dec.rs1   = instr[19:15];
        dec.rs2   = instr[24:20];
        dec.fn3   = instr[14:12];
        dec.fn7_5 = instr[30];
        dec.fn7_1 = instr[25];
      end
      is_i: begin
        dec.fmt = F_I;
        dec.rd  = instr[11:7];
        dec.rs1 = instr[19:15];
        dec.fn3 = instr[14:12];
        dec.imm = sext({{20{instr[31]}},
                        instr[31:20]});
      end
      is_s: begin
        dec.fmt = F_S;
        dec.rs1 = instr[19:15];
        dec.rs2 = instr[24:20];
        dec.fn3 = instr[14:12];
        dec.imm = sext({{20{instr[31]}},
                        instr[31:25],
                        instr[11:7]});
      end
      is_b: begin
        dec.fmt = F_B;
        dec.rs1 = instr[19:15];
        dec.rs2 = instr[24:20];
        dec.fn3 = instr[14:12];
        dec.imm = sext({{19{instr[31]}},
                        instr[31], instr[7],
                        instr[30:25],
                        instr[11:8], 1'b0});
      end
      is_u: begin
        dec.fmt = F_U;
        dec.rd  = instr[11:7];
        dec.imm = sext({instr[31:12], 12'b0});
      end
      is_j: begin
        dec.fmt = F_J;
        dec.rd  = instr[11:7];
        dec.imm = sext({{11{instr[31]}},
                        instr[31],
                        instr[19:12],
                        instr[20],
                        instr[30:21], 1'b0});
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  assign out_valid = (state_q != EMPTY);
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (push) state_d = ONE;
        ONE: begin
          if (push && !pop) state_d = TWO;
          else if (!push && pop) state_d = EMPTY;
        end
        TWO: if (pop) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      in_ready <= 1'b0;
      head     <= '0;
      tail     <= '0;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d != TWO);
      if (flush) begin
        head <= '0;
        tail <= '0;
      end else begin
        unique case (state_q)
          EMPTY: if (push) head <= dec;
          ONE: begin
            if (push && pop) head <= dec;
            else if (push) tail <= dec;
          end
          TWO: if (pop) head <= tail;
          default: ;
        endcase
      end
    end
  end

  assign pc_out  = head.pc;
  assign opcode  = head.opcode;
  assign rd      = head.rd;
  assign rs1     = head.rs1;
  assign rs2     = head.rs2;
  assign fn3     = head.fn3;
  assign fn7_5   = head.fn7_5;
  assign fn7_1   = head.fn7_1;
  assign imm     = head.imm;
  assign fmt     = head.fmt;
  assign illegal = head.illegal;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe: decode
// formats, skid-buffer flow, flush, reset.
module tb_decode_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pc_out;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  fn3;
  logic        fn7_5, fn7_1;
  logic [31:0] imm;
  logic [2:0]  fmt;
  logic        illegal;

  int tests = 0;
  int fails = 0;

  decode_pipe #(.XLEN(32), .ILEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc_in(pc_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc_out(pc_out), .opcode(opcode),
    .rd(rd), .rs1(rs1), .rs2(rs2), .fn3(fn3),
    .fn7_5(fn7_5), .fn7_1(fn7_1), .imm(imm),
    .fmt(fmt), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single cycle.
  task automatic send(input logic [31:0] i,
                      input logic [31:0] p);
    in_valid = 1'b1;
    instr    = i;
    pc_in    = p;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0;
    in_valid = 1'b1; instr = 32'hFFF30293;
    pc_in = 32'h10; out_ready = 1'b0;
    tick(); tick();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_hs: v=%b r=%b need 0 0",
               out_valid, in_ready);
    end
    tests++;
    if ({pc_out, imm, rd, rs1, fmt, illegal}
        !== '0) begin
      fails++;
      $display("FAIL reset_data: pc=%h imm=%h fmt=%0d need 0",
               pc_out, imm, fmt);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: r=%b v=%b need 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    send(32'hFFF30293, 32'h100);
    tests++;
    if (out_valid !== 1'b1 || rd !== 5'd5 ||
        rs1 !== 5'd6 || rs2 !== 5'd0 ||
        fmt !== 3'd1 || imm !== 32'hFFFFFFFF ||
        illegal !== 1'b0 || opcode !== 7'h13 ||
        pc_out !== 32'h100) begin
      fails++;
      $display("FAIL addi: v=%b rd=%0d rs1=%0d rs2=%0d fmt=%0d imm=%h ill=%b pc=%h need 1 5 6 0 1 ffffffff 0 100",
               out_valid, rd, rs1, rs2, fmt, imm,
               illegal, pc_out);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL addi_drain: v=%b need 0",
               out_valid);
    end
  endtask

  task automatic test_beq();
    out_ready = 1'b1;
    send(32'hFE208CE3, 32'h104);
    tests++;
    if (fmt !== 3'd3 || rs1 !== 5'd1 ||
        rs2 !== 5'd2 || rd !== 5'd0 ||
        fn3 !== 3'd0 || imm !== 32'hFFFFFFF8) begin
      fails++;
      $display("FAIL beq: fmt=%0d rs1=%0d rs2=%0d rd=%0d imm=%h need 3 1 2 0 fffffff8",
               fmt, rs1, rs2, rd, imm);
    end
    tick();
  endtask

  task automatic test_formats();
    out_ready = 1'b1;
    send(32'h402081B3, 32'h110);
    tests++;
    if (fmt !== 3'd0 || rd !== 5'd3 ||
        rs1 !== 5'd1 || rs2 !== 5'd2 ||
        fn7_5 !== 1'b1 || fn7_1 !== 1'b0 ||
        imm !== 32'h0) begin
      fails++;
      $display("FAIL sub: fmt=%0d rd=%0d f5=%b f1=%b imm=%h need 0 3 1 0 0",
               fmt, rd, fn7_5, fn7_1, imm);
    end
    send(32'h0020A423, 32'h114);
    tests++;
    if (fmt !== 3'd2 || rd !== 5'd0 ||
        rs1 !== 5'd1 || rs2 !== 5'd2 ||
        fn3 !== 3'd2 || imm !== 32'h8) begin
      fails++;
      $display("FAIL sw: fmt=%0d rd=%0d rs1=%0d rs2=%0d fn3=%0d imm=%h need 2 0 1 2 2 8",
               fmt, rd, rs1, rs2, fn3, imm);
    end
    send(32'hFFDFF0EF, 32'h118);
    tests++;
    if (fmt !== 3'd5 || rd !== 5'd1 ||
        rs1 !== 5'd0 || fn3 !== 3'd0 ||
        imm !== 32'hFFFFFFFC) begin
      fails++;
      $display("FAIL jal: fmt=%0d rd=%0d rs1=%0d imm=%h need 5 1 0 fffffffc",
               fmt, rd, rs1, imm);
    end
    tick();
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    send(32'h00000000, 32'h120);
    tests++;
    if (out_valid !== 1'b1 || illegal !== 1'b1 ||
        fmt !== 3'd7 || imm !== 32'h0 ||
        rd !== 5'd0 || opcode !== 7'h00) begin
      fails++;
      $display("FAIL zero_instr: v=%b ill=%b fmt=%0d imm=%h need 1 1 7 0",
               out_valid, illegal, fmt, imm);
    end
    send(32'hFFFFFFF0, 32'h124);
    tests++;
    if (illegal !== 1'b1 || fmt !== 3'd7 ||
        opcode !== 7'h70 || rs1 !== 5'd0 ||
        fn3 !== 3'd0 || imm !== 32'h0) begin
      fails++;
      $display("FAIL low_bits: ill=%b fmt=%0d op=%h rs1=%0d imm=%h need 1 7 70 0 0",
               illegal, fmt, opcode, rs1, imm);
    end
    send(32'h800000B7, 32'h128);
    tests++;
    if (fmt !== 3'd4 || rd !== 5'd1 ||
        rs1 !== 5'd0 || illegal !== 1'b0 ||
        imm !== 32'h80000000) begin
      fails++;
      $display("FAIL lui: fmt=%0d rd=%0d rs1=%0d imm=%h need 4 1 0 80000000",
               fmt, rd, rs1, imm);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid = 1'b1;
    instr = 32'hFFF30293; pc_in = 32'h200;
    tick();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 ||
        pc_out !== 32'h200) begin
      fails++;
      $display("FAIL b2b_first: r=%b v=%b pc=%h need 1 1 200",
               in_ready, out_valid, pc_out);
    end
    instr = 32'hFE208CE3; pc_in = 32'h204;
    tick();
    tests++;
    if (in_ready !== 1'b0 || pc_out !== 32'h200) begin
      fails++;
      $display("FAIL b2b_full: r=%b pc=%h need 0 200",
               in_ready, pc_out);
    end
    instr = 32'h800000B7; pc_in = 32'h208;
    tick();
    tests++;
    if (in_ready !== 1'b0 || pc_out !== 32'h200 ||
        imm !== 32'hFFFFFFFF || rd !== 5'd5) begin
      fails++;
      $display("FAIL b2b_hold: r=%b pc=%h imm=%h need 0 200 ffffffff",
               in_ready, pc_out, imm);
    end
    out_ready = 1'b1;
    tick();
    tests++;
    if (out_valid !== 1'b1 || pc_out !== 32'h204 ||
        fmt !== 3'd3 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_second: v=%b pc=%h fmt=%0d r=%b need 1 204 3 1",
               out_valid, pc_out, fmt, in_ready);
    end
    tick();
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || pc_out !== 32'h208 ||
        imm !== 32'h80000000) begin
      fails++;
      $display("FAIL b2b_third: v=%b pc=%h imm=%h need 1 208 80000000",
               out_valid, pc_out, imm);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_drain: v=%b need 0",
               out_valid);
    end
  endtask

  task automatic test_stream();
    int bad = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    instr = 32'h00000013;
    for (int k = 0; k < 6; k++) begin
      pc_in = 32'h300 + 32'(4 * k);
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b1 ||
          pc_out !== 32'h300 + 32'(4 * k)) begin
        bad++;
        $display("FAIL stream_%0d: v=%b r=%b pc=%h need 1 1 %h",
                 k, out_valid, in_ready, pc_out,
                 32'h300 + 32'(4 * k));
      end
    end
    in_valid = 1'b0;
    tests++;
    if (bad != 0) fails++;
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(32'hFFF30293, 32'h400);
    send(32'hFE208CE3, 32'h404);
    tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL flush_setup: r=%b v=%b need 0 1",
               in_ready, out_valid);
    end
    flush = 1'b1;
    in_valid = 1'b1;
    instr = 32'h800000B7; pc_in = 32'h408;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush: v=%b r=%b need 0 1",
               out_valid, in_ready);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_quiet: v=%b pc=%h need 0",
               out_valid, pc_out);
    end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    send(32'h800000B7, 32'h500);
    in_valid = 1'b1;
    instr = 32'hFE208CE3; pc_in = 32'h504;
    rst_n = 1'b0;
    tick();
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 ||
        pc_out !== 32'h0 || imm !== 32'h0 ||
        rd !== 5'd0 || opcode !== 7'h0) begin
      fails++;
      $display("FAIL mid_reset: v=%b r=%b pc=%h imm=%h need 0 0 0 0",
               out_valid, in_ready, pc_out, imm);
    end
    rst_n = 1'b1;
    tick();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_release: r=%b v=%b need 1 0",
               in_ready, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_beq();
    test_formats();
    test_illegal();
    test_back_to_back();
    test_stream();
    test_flush();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
